// File: rtl/rv_instr_encoder_if.sv
// rv_instr_encoder_if: request/response bus for the RV32I instruction encoder.
//   master drives requests (in_*) and out_ready.
//   slave (the encoder) returns in_ready, out_valid/out_instr, err_pulse and the counters.
interface rv_instr_encoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_class;
  logic [2:0]       in_funct3;
  logic             in_alt;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [12:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err_pulse;
  logic [CNT_W-1:0] instr_cnt;
  logic [7:0]       err_cnt;
  modport master (
    output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, err_pulse, instr_cnt, err_cnt
  );
  modport slave (
    input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, err_pulse, instr_cnt, err_cnt
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: assembles RV32I R/I/load/store/branch words from field requests into a FIFO.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave modport; request handshake in, instruction FIFO head out, error pulse and counters
module rv_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rv_instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic [31:0]      r_out;
  logic             r_err;
  logic [CNT_W-1:0] r_icnt;
  logic [7:0]       r_ecnt;
  logic             w_acc;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic             w_sh;
  logic [31:0]      w_enc;
  logic [31:0]      w_head;
  logic [AW:0]      w_left;
  logic [AW-1:0]    w_rd_nx;
  assign bus.in_ready  = r_count != FULL;
  assign bus.out_valid = r_count != '0;
  assign bus.out_instr = r_out;
  assign bus.err_pulse = r_err;
  assign bus.instr_cnt = r_icnt;
  assign bus.err_cnt   = r_ecnt;
  assign w_acc   = bus.in_valid && bus.in_ready;
  assign w_legal = bus.in_class <= 3'd4;
  assign w_push  = w_acc && w_legal;
  assign w_pop   = bus.out_valid && bus.out_ready;
  // funct3 001/101 are the immediate shifts: shamt in imm[4:0], bit 30 selects srai
  assign w_sh    = bus.in_funct3[1:0] == 2'b01;
  always_comb begin
    w_enc = (bus.in_class == 3'd0) ? {1'b0, bus.in_alt, 5'b0, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011} :
            (bus.in_class == 3'd1) ? (w_sh ? {1'b0, bus.in_alt, 5'b0, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011}
                                           : {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011}) :
            (bus.in_class == 3'd2) ? {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011} :
            (bus.in_class == 3'd3) ? {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0], 7'b0100011} :
                                     {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
  end
  // out_instr is a register tracking the post-edge head; if the FIFO drains to
  // empty with a push, the new head is the word being written this cycle
  assign w_left  = r_count - (AW+1)'(w_pop);
  assign w_rd_nx = r_rd + AW'(w_pop);
  assign w_head  = (w_left == '0) ? w_enc : r_mem[w_rd_nx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
      r_icnt  <= '0;
      r_ecnt  <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= w_enc;
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= w_rd_nx;
      r_count <= w_left + (AW+1)'(w_push);
      if (w_left != '0 || w_push) r_out <= w_head;
      r_err   <= w_acc && !w_legal;
      if (w_pop) r_icnt <= r_icnt + 1'b1;
      if (w_acc && !w_legal && r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: directed-vector bench for rv_instr_encoder with hand-computed expected words.
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  rv_instr_encoder_if #(.CNT_W(16)) bus ();
  rv_instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic set_req(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_class  = cls;
    bus.in_funct3 = f3;
    bus.in_alt    = alt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask
  // called at a negedge; returns at the negedge after the accepting posedge with in_valid low
  task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm);
    int k;
    set_req(cls, f3, alt, rd, rs1, rs2, imm);
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic enc(input string tag, input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [12:0] imm, input logic [31:0] exp);
    send(cls, f3, alt, rd, rs1, rs2, imm);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk(tag, bus.out_instr, exp);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    chk("rst_instr_cnt", 32'(bus.instr_cnt), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    enc("r_add",  3'd0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0,      32'h003100B3);
    enc("r_sub",  3'd0, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 13'd0,      32'h403100B3);
    enc("addi",   3'd1, 3'b000, 1'b1, 5'd5, 5'd0, 5'd9, 13'h1FFF,   32'hFFF00293);
    enc("srai",   3'd1, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 13'd3,      32'h4030D093);
    enc("lw",     3'd2, 3'b010, 1'b1, 5'd4, 5'd1, 5'd7, 13'd0,      32'h0000A203);
    enc("sw",     3'd3, 3'b010, 1'b1, 5'd9, 5'd2, 5'd3, 13'd8,      32'h00312423);
    enc("beq",    3'd4, 3'b000, 1'b1, 5'd9, 5'd1, 5'd2, 13'h1FFC,   32'hFE208EE3);
    chk("cnt_after_7", 32'(bus.instr_cnt), 32'd7);
    chk("empty_after_7", 32'(bus.out_valid), 32'd0);
    chk("empty_holds", bus.out_instr, 32'hFE208EE3);
    // backpressure: DEPTH=2, third request must wait for a pop
    do_reset();
    bus.out_ready = 1'b0;
    set_req(3'd0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0);
    chk("bp_rdy0", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    set_req(3'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 13'h1FFF);
    chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
    chk("bp_head_a", bus.out_instr, 32'h003100B3);
    @(negedge clk);
    set_req(3'd2, 3'b010, 1'b0, 5'd4, 5'd1, 5'd0, 13'd0);
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_full_held", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_a", bus.out_instr, 32'h003100B3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_after_pop", 32'(bus.in_ready), 32'd1);
    chk("bp_head_b", bus.out_instr, 32'hFFF00293);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_head_c_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_c", bus.out_instr, 32'h0000A203);
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_cnt", 32'(bus.instr_cnt), 32'd3);
    // illegal classes
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
    chk("ill_pulse", 32'(bus.err_pulse), 32'd1);
    chk("ill_cnt1", 32'(bus.err_cnt), 32'd1);
    chk("ill_no_push", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("ill_pulse_end", 32'(bus.err_pulse), 32'd0);
    chk("ill_still_empty", 32'(bus.out_valid), 32'd0);
    set_req(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
    repeat (253) @(negedge clk);
    chk("ill_cnt254", 32'(bus.err_cnt), 32'd254);
    repeat (46) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ill_sat", 32'(bus.err_cnt), 32'd255);
    chk("ill_instr_cnt", 32'(bus.instr_cnt), 32'd3);
    @(negedge clk);
    chk("ill_sat_hold", 32'(bus.err_cnt), 32'd255);
    // reset with two words buffered
    bus.out_ready = 1'b0;
    send(3'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 13'd8);
    send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC);
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    do_reset();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_icnt", 32'(bus.instr_cnt), 32'd0);
    chk("mid_rst_ecnt", 32'(bus.err_cnt), 32'd0);
    chk("mid_rst_instr", bus.out_instr, 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_emit", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_cnt_stay", 32'(bus.instr_cnt), 32'd0);
    enc("post_rst_sw", 3'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 13'd8, 32'h00312423);
    chk("post_rst_cnt", 32'(bus.instr_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Encoder counterpart to the main control unit's opcode decoder.
- Accepts field-level instruction requests (class, funct3, registers, immediate) over a valid/ready handshake.
- Assembles legal 32-bit RV32I words for the five classes the control unit decodes: R-type, I-type ALU, load, store and branch.
- Buffers the words in a small FIFO for the instruction-memory loader and test program generators. Rejects and counts illegal classes.

Parameters:
DEPTH, 2, output FIFO entries; power of two, 2 or more.
CNT_W, 16, width of emitted-instruction counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid and in_ready are both high
in_class  input  3  0=R, 1=I-ALU, 2=load, 3=store, 4=branch, 5-7 illegal
in_funct3  input  3  funct3 field
in_alt  input  1  instruction bit 30 (sub/sra/srai); ignored for load/store/branch and for non-shift I-type
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  13  signed immediate; I/load/store use [11:0], branch uses [12:1]
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer ready
out_instr  output  32  FIFO head instruction word
err_pulse  output  1  one-cycle pulse, illegal class accepted
instr_cnt  output  CNT_W  words emitted (popped), wraps
err_cnt  output  8  illegal requests, saturates at 255

Behaviour:
- Reset: all of the following are 0 at the first edge with rst_n=0, regardless of state:
  - out_valid, err_pulse, instr_cnt, err_cnt.
  - FIFO pointers and occupancy, so in_ready=1 after reset.
  - out_instr.
- Reset mid-operation discards all buffered words.
- Accept: handshake when in_valid && in_ready.
  - in_ready = !full, combinational from occupancy only, independent of in_valid and out_ready.
  - Legal class: the encoded word is pushed; out_valid is high no earlier than the next cycle (latency 1).
  - Illegal class: the request is consumed and nothing is pushed. err_pulse is high the next cycle; err_cnt increments, saturating.
- Encoding (bit fields MSB→LSB):
  - R: {1'b0, in_alt, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}.
  - I:
    - funct3 = 001 or 101: {1'b0, in_alt, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011}.
    - Otherwise: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
  - Load: {imm[11:0], rs1, funct3, rd, 7'b0000011}.
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
  - Branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}; in_imm[0] ignored.
  - Unused fields for a class are ignored. No funct3 legality check.
- FIFO:
  - Pop when out_valid && out_ready; out_instr = head word.
  - out_instr holds its value while out_valid && !out_ready.
  - Pointers wrap modulo DEPTH. Order is strictly preserved.
  - Push and pop in the same cycle: both occur and occupancy is unchanged.
  - When full, in_ready=0, so a same-cycle pop does not open a slot until the next cycle. There is no combinational pass-through.
  - When empty, out_valid=0 and out_instr holds its last value.
- Counters:
  - instr_cnt increments on each pop, wrapping at 2^CNT_W.
  - err_cnt stops at 255.
  - Neither counter changes except on its event or reset.

Test Plan:
- R-type: class 0, rd=1, rs1=2, rs2=3, funct3=0, alt=0 → out_instr 0x003100B3 one cycle after accept. Same request with alt=1 → 0x403100B3.
- I-type and load:
  - addi x5,x0,-1 (imm=0x1FFF) → 0xFFF00293.
  - srai x1,x1,3 (funct3=101, alt=1, imm=3) → 0x4030D093.
  - lw x4,0(x1) (class 2, funct3=010) → 0x0000A203.
- Store and branch:
  - sw x3,8(x2) → 0x00312423.
  - beq x1,x2,-4 (imm=0x1FFC) → 0xFE208EE3.
- Backpressure: out_ready=0, three back-to-back requests.
  - First two are accepted; in_ready drops after the second; the third is held.
  - Raise out_ready: words pop in order, the third is accepted the cycle after the first pop, and instr_cnt ends at 3.
- Illegal class 6 → consumed, err_pulse high for exactly 1 cycle, err_cnt=1, out_valid stays 0. After 300 illegal requests, err_cnt=255.
- With 2 words buffered, assert rst_n=0 for 1 cycle → out_valid=0, in_ready=1, counters 0, and the old words are never emitted.
